// File: rtl/lcd_pclk_gen.sv
// lcd_pclk_gen: divided LCD pixel clock with glitch-free divisor changes and settle gap
module lcd_pclk_gen #(
    parameter int DIV_W  = 8,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      lcd_id,
    input  logic             id_valid,
    input  logic             div_ovr_en,
    input  logic [DIV_W-1:0] div_ovr,
    output logic             lcd_pclk,
    output logic             pclk_rise,
    output logic             bypass,
    output logic             locked,
    output logic [DIV_W-1:0] cur_div
);
    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN, ST_SETTLE} state_t;
    state_t           state;
    logic [DIV_W-1:0] tgt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] dec;
    logic [DIV_W-1:0] nt;
    logic [DIV_W-1:0] nc;
    logic [DIV_W-1:0] half;
    logic [7:0]       scnt;
    logic             last;

    // Decode the panel ID, select the incoming target and the next phase count
    always_comb begin
        dec  = (lcd_id == 16'h4342) ? DIV_W'(4) :
               (lcd_id == 16'h7084 || lcd_id == 16'h4384) ? DIV_W'(2) :
               (lcd_id == 16'h7016 || lcd_id == 16'h1018) ? DIV_W'(1) : '0;
        nt   = id_valid ? (div_ovr_en ? div_ovr : dec) : tgt;
        last = cnt == cur_div - DIV_W'(1);
        nc   = last ? '0 : cnt + DIV_W'(1);
        half = cur_div >> 1;
    end

    // Mode FSM; a running period always completes before the settle gap starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            tgt       <= '0;
            cnt       <= '0;
            scnt      <= '0;
            cur_div   <= '0;
            lcd_pclk  <= 1'b0;
            pclk_rise <= 1'b0;
            bypass    <= 1'b0;
            locked    <= 1'b0;
        end else begin
            tgt <= nt;
            case (state)
                ST_OFF: begin
                    if (tgt != '0) begin
                        state <= ST_SETTLE;
                        scnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (nt != cur_div) begin
                        locked    <= 1'b0;
                        bypass    <= 1'b0;
                        pclk_rise <= 1'b0;
                        if (last) begin
                            state    <= ST_SETTLE;
                            scnt     <= '0;
                            cnt      <= '0;
                            lcd_pclk <= 1'b0;
                        end else begin
                            state    <= ST_DRAIN;
                            cnt      <= nc;
                            lcd_pclk <= nc < half;
                        end
                    end else begin
                        cnt       <= nc;
                        lcd_pclk  <= nc < half;
                        pclk_rise <= nc == '0;
                    end
                end
                ST_DRAIN: begin
                    if (last) begin
                        state    <= ST_SETTLE;
                        scnt     <= '0;
                        cnt      <= '0;
                        lcd_pclk <= 1'b0;
                    end else begin
                        cnt      <= nc;
                        lcd_pclk <= nc < half;
                    end
                end
                default: begin
                    if (scnt == 8'(SETTLE - 1)) begin
                        cur_div <= tgt;
                        cnt     <= '0;
                        if (tgt == '0) begin
                            state <= ST_OFF;
                        end else begin
                            state     <= ST_RUN;
                            lcd_pclk  <= tgt >= DIV_W'(2);
                            pclk_rise <= 1'b1;
                            bypass    <= tgt == DIV_W'(1);
                            locked    <= 1'b1;
                        end
                    end else begin
                        scnt <= scnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_pclk_gen.sv
// tb_lcd_pclk_gen: directed checks of start-up, divisor changes, bypass, override and reset
module tb_lcd_pclk_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] lcd_id = '0;
    logic        id_valid = 1'b0;
    logic        div_ovr_en = 1'b0;
    logic [7:0]  div_ovr = '0;
    logic        lcd_pclk;
    logic        pclk_rise;
    logic        bypass;
    logic        locked;
    logic [7:0]  cur_div;
    int          n_run = 0;
    int          n_fail = 0;

    lcd_pclk_gen #(.DIV_W(8), .SETTLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_id(lcd_id), .id_valid(id_valid),
        .div_ovr_en(div_ovr_en), .div_ovr(div_ovr), .lcd_pclk(lcd_pclk),
        .pclk_rise(pclk_rise), .bypass(bypass), .locked(locked), .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_run++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] id);
        id_valid = 1'b1;
        lcd_id   = id;
        step();
        id_valid = 1'b0;
    endtask

    task automatic seq(input string tag, input int len, input logic [15:0] p,
                       input logic [15:0] r, input logic [15:0] l, input logic [15:0] b);
        for (int i = 0; i < len; i++) begin
            int k;
            k = len - 1 - i;
            chk($sformatf("%s[%0d].pclk", tag, i), lcd_pclk, p[k]);
            chk($sformatf("%s[%0d].rise", tag, i), pclk_rise, r[k]);
            chk($sformatf("%s[%0d].lock", tag, i), locked, l[k]);
            chk($sformatf("%s[%0d].byp", tag, i), bypass, b[k]);
            step();
        end
    endtask

    initial begin
        step();
        step();
        seq("reset", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.cur_div", cur_div, 0);
        rst_n = 1'b1;
        seq("idle", 3, 3'b0, 3'b0, 3'b0, 3'b0);
        strobe(16'h4342);
        seq("div4", 13, 13'b0000011001100, 13'b0000010001000, 13'b0000011111111, 13'b0);
        chk("div4.cur_div", cur_div, 4);
        step();
        strobe(16'h7084);
        seq("to2", 10, 10'b0000001010, 10'b0000001010, 10'b0000001111, 10'b0);
        chk("to2.cur_div", cur_div, 2);
        strobe(16'h4384);
        seq("same2", 3, 3'b010, 3'b010, 3'b111, 3'b000);
        strobe(16'h7016);
        seq("bypass", 8, 8'b0, 8'b00000111, 8'b00000111, 8'b00000111);
        chk("bypass.cur_div", cur_div, 1);
        div_ovr_en = 1'b1;
        div_ovr    = 8'd5;
        strobe(16'h0000);
        div_ovr_en = 1'b0;
        seq("ovr5", 14, 14'b00001100011000, 14'b00001000010000, 14'b00001111111111, 14'b0);
        chk("ovr5.cur_div", cur_div, 5);
        strobe(16'hFFFF);
        seq("off", 12, 12'b100000000000, 12'b0, 12'b0, 12'b0);
        chk("off.cur_div", cur_div, 0);
        strobe(16'h4342);
        step();
        strobe(16'h7084);
        seq("latest", 7, 7'b0001010, 7'b0001010, 7'b0001111, 7'b0);
        chk("latest.cur_div", cur_div, 2);
        chk("pre_rst.pclk", lcd_pclk, 1);
        #1 rst_n = 1'b0;
        #1;
        seq("async_rst", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_rst.cur_div", cur_div, 0);
        #1 rst_n = 1'b1;
        seq("post_rst", 6, 6'b0, 6'b0, 6'b0, 6'b0);
        chk("post_rst.cur_div", cur_div, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
